// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg: shared FSM encoding and default widths for the arbitrated register bank.
// Optional feature macro: REG_BANK_ARB_FIXED_PRI_EN (fixed-priority arbitration). Rev 1.0
`default_nettype none

package reg_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam int DEF_DATA_W = 6;
  localparam int DEF_ADDR_W = 2;

endpackage

`default_nettype wire

// File: rtl/reg_bank_arbiter_rr_pick.sv
// reg_bank_arbiter_rr_pick: combinational winner select (round-robin from ptr, or fixed priority
// when REG_BANK_ARB_FIXED_PRI_EN is defined). Rev 1.0
`default_nettype none

module reg_bank_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

`ifdef REG_BANK_ARB_FIXED_PRI_EN
  // Pointer is meaningless under fixed priority; fold it into a sink to keep the port uniform.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end
`else
  logic found;
  int   k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    k      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        onehot[k] = 1'b1;
        idx       = IDX_W'(k);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: NUM_REGS x DATA_W register bank shared by NUM_REQ requesters via req/grant/ack.
// Optional feature macro: REG_BANK_ARB_FIXED_PRI_EN (fixed priority, no rr pointer). Rev 1.0
`default_nettype none

module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         wr,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              state;
  state_t              state_nxt;
  logic [NUM_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    ptr;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic [DATA_W-1:0]   bank [NUM_REGS];
  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  reg_bank_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (win_oh),
    .idx    (win_idx)
  );

`ifdef REG_BANK_ARB_FIXED_PRI_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] lat_idx;

  // Pointer advances only when a grant completes, so an aborted transaction leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= '0;
      lat_idx <= '0;
    end else begin
      if (state == IDLE && |req)
        lat_idx <= win_idx;
      if (state == ACCESS)
        ptr <= (lat_idx == IDX_W'(NUM_REQ - 1)) ? '0 : lat_idx + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured at grant so requester changes during ACCESS cannot corrupt the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant    <= '0;
      ack      <= '0;
      rdata    <= '0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (|req) begin
            grant    <= win_oh;
            lat_wr   <= wr[win_idx];
            lat_addr <= addr_a[win_idx];
            lat_data <= wdata_a[win_idx];
          end
        end
        ACCESS: begin
          ack   <= grant;
          grant <= '0;
          if (!lat_wr)
            rdata <= bank[lat_addr];
        end
        DONE: begin
          ack <= '0;
        end
        default: begin
          grant <= '0;
          ack   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++)
        bank[k] <= '0;
    end else if (state == ACCESS && lat_wr) begin
      bank[lat_addr] <= lat_data;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign reg_out[k*DATA_W +: DATA_W] = bank[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed scoreboard bench for reg_bank_arbiter (honours REG_BANK_ARB_FIXED_PRI_EN).
`default_nettype none

module tb_reg_bank_arbiter;

  localparam int NR = 4;
  localparam int NG = 4;
  localparam int DW = 6;
  localparam int AW = 2;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req   = '0;
  logic [NR-1:0]     wr    = '0;
  logic [NR*AW-1:0]  addr  = '0;
  logic [NR*DW-1:0]  wdata = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic [NG*DW-1:0]  reg_out;

  reg_bank_arbiter #(
    .NUM_REQ  (NR),
    .NUM_REGS (NG),
    .DATA_W   (DW),
    .ADDR_W   (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .grant   (grant),
    .ack     (ack),
    .rdata   (rdata),
    .reg_out (reg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] ack;
    logic          is_rd;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_bank [NG];
  int            m_ptr;
  logic [DW-1:0] m_rdata;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_regs();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < NG; k++)
      v[k*DW +: DW] = m_bank[k];
    return v;
  endfunction

  function automatic int pick(input logic [NR-1:0] r, input int p);
`ifdef REG_BANK_ARB_FIXED_PRI_EN
    for (int i = 0; i < NR; i++)
      if (r[i]) return i;
`else
    for (int off = 0; off < NR; off++)
      if (r[(p + off) % NR]) return (p + off) % NR;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NG; k++) m_bank[k] = '0;
    m_ptr   = 0;
    m_rdata = '0;
  endtask

  // Push the predicted outcome, wait (bounded) for ack, then pop and compare.
  task automatic run_txn(input string tag, input int lat, input bit do_chg,
                         input logic [NR*DW-1:0] chg_wdata);
    exp_t e;
    exp_t got;
    int   w;
    int   a;
    int   n;
    w       = pick(req, m_ptr);
    a       = int'(addr[w*AW +: AW]);
    e.ack   = NR'(1) << w;
    e.is_rd = !wr[w];
    if (e.is_rd) m_rdata = m_bank[a];
    else         m_bank[a] = wdata[w*DW +: DW];
    e.rdata = m_rdata;
    m_ptr   = (w + 1) % NR;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == lat - 1 && ack == '0) begin
        check({tag, "_grant"}, 32'(grant), 32'(e.ack));
        if (do_chg) wdata = chg_wdata;
      end
    end while (ack == '0 && n < lat + 4);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    got = sb.pop_front();
    check({tag, "_ack"}, 32'(ack), 32'(got.ack));
    check({tag, "_rdata"}, 32'(rdata), 32'(got.rdata));
    check({tag, "_reg_out"}, 32'(reg_out), model_regs());
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      check("grant_ack_excl", 32'(|(grant & ack)), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_reg_out", 32'(reg_out), 32'd0);
    reset = 1'b1;

    // Requester 0 writes 0x2A to register 2
    req = 4'b0001; wr = 4'b0001;
    addr[0*AW +: AW] = 2'd2; wdata[0*DW +: DW] = 6'h2A;
    run_txn("wr0", 2, 1'b0, '0);
    check("wr0_slice2", 32'(reg_out), 32'h0002_A000);
    req = '0;
    @(negedge clk);

    // Requester 1 reads register 2 back; rdata must hold afterwards
    req = 4'b0010; wr = 4'b0000; addr[1*AW +: AW] = 2'd2;
    run_txn("rd1", 2, 1'b0, '0);
    check("rd1_value", 32'(rdata), 32'h2A);
    req = '0;
    @(negedge clk);
    check("rd1_hold", 32'(rdata), 32'h2A);

    // Fresh reset so rotation starts at pointer 0; all four write distinct data
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst2_reg_out", 32'(reg_out), 32'd0);
    reset = 1'b1;
    req = 4'b1111; wr = 4'b1111;
    for (int i = 0; i < NR; i++) begin
      addr[i*AW +: AW]  = AW'(i);
      wdata[i*DW +: DW] = DW'(6'h10 + i);
    end
    run_txn("rr_a", 2, 1'b0, '0);
    run_txn("rr_b", 3, 1'b0, '0);
    run_txn("rr_c", 3, 1'b0, '0);
    run_txn("rr_d", 3, 1'b0, '0);
    run_txn("rr_e", 3, 1'b0, '0);
    req = '0;
    @(negedge clk);

    // Requester 3 changes wdata during ACCESS; latched 0x01 must land in register 1
    req = 4'b1000; wr = 4'b1000;
    addr[3*AW +: AW] = 2'd1; wdata[3*DW +: DW] = 6'h01;
    run_txn("latch3", 2, 1'b1, {6'h3F, wdata[3*DW-1:0]});
    check("latch3_reg1", 32'(reg_out[1*DW +: DW]), 32'h01);
    req = '0;
    @(negedge clk);

    // Reset during ACCESS aborts a pending write of 0x15 to register 3
    req = 4'b0001; wr = 4'b0001;
    addr[0*AW +: AW] = 2'd3; wdata[0*DW +: DW] = 6'h15;
    @(negedge clk);
    check("abort_grant_pre", 32'(grant), 32'h1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    req = '0;
    @(negedge clk);
    check("abort_ack2", 32'(ack), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ack3", 32'(ack), 32'd0);
    check("abort_reg3", 32'(reg_out[3*DW +: DW]), 32'd0);
    // FSM must be back in IDLE: a new request gets granted after one cycle
    req = 4'b0100; wr = 4'b0000; addr[2*AW +: AW] = 2'd3;
    run_txn("post_abort", 2, 1'b0, '0);
    req = '0;
    @(negedge clk);

    // req 0 and 2 held: fixed priority starves 2, round-robin alternates
    req = 4'b0101; wr = 4'b0000;
    addr[0*AW +: AW] = 2'd1; addr[2*AW +: AW] = 2'd3;
    run_txn("pri_a", 2, 1'b0, '0);
    run_txn("pri_b", 3, 1'b0, '0);
    run_txn("pri_c", 3, 1'b0, '0);
    run_txn("pri_d", 3, 1'b0, '0);
    req = 4'b0100;
    run_txn("pri_e", 3, 1'b0, '0);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
